// File: rtl/fc_requant_buffer.sv
// Requantises FC accumulator lanes to 4-bit activations, buffers them,
// and replays them as the serial input stream of the next layer.
module fc_requant_buffer #(
  parameter int ACC_W  = 44,
  parameter int ACT_W  = 4,
  parameter int DEPTH  = 64,
  parameter int SHIFT0 = 8,
  parameter int SHIFT1 = 8,
  parameter int SHIFT2 = 6,
  parameter int SHIFT3 = 4
) (
  input  logic             clk,
  input  logic             rst_fsm,
  input  logic [1:0]       layer_fc,
  input  logic             acc_valid,
  input  logic [ACC_W-1:0] o_data1,
  input  logic [ACC_W-1:0] o_data2,
  input  logic [ACC_W-1:0] o_data3,
  input  logic [ACC_W-1:0] o_data4,
  output logic             acc_ready,
  input  logic             rd_start,
  output logic [ACT_W-1:0] i_data,
  output logic             data_valid,
  output logic             layer_done,
  output logic [6:0]       count,
  output logic             ovf_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] QUANT = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SH_W  = $clog2(ACC_W + 1);
  localparam logic [6:0] FILL_MAX = 7'(DEPTH - 4);

  logic [1:0]       state;
  logic [ACC_W-1:0] lane_q [4];
  logic [SH_W-1:0]  sh_q;
  logic [SH_W-1:0]  sh_sel;
  logic [1:0]       lane_idx;
  logic [PTR_W-1:0] wr_ptr;
  logic [6:0]       rd_ptr;
  logic [ACT_W-1:0] mem [DEPTH];

  logic [ACC_W-1:0] v;
  logic [ACC_W:0]   rnd;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   shr;
  logic [ACT_W-1:0] q;
  logic             take_acc;

  assign acc_ready = (state == IDLE) && (count <= FILL_MAX);
  assign take_acc  = acc_valid && acc_ready;

  always_comb begin
    sh_sel = '0;
    unique case (layer_fc)
      2'd0: sh_sel = SH_W'(SHIFT0);
      2'd1: sh_sel = SH_W'(SHIFT1);
      2'd2: sh_sel = SH_W'(SHIFT2);
      2'd3: sh_sel = SH_W'(SHIFT3);
      default: sh_sel = '0;
    endcase
  end

  // One extra bit keeps the rounding add from wrapping near +max
  always_comb begin
    v   = lane_q[lane_idx];
    rnd = (ACC_W+1)'(1) << (sh_q - SH_W'(1));
    sum = {1'b0, v} + rnd;
    shr = sum >> sh_q;
    q   = '0;
    if (v[ACC_W-1])
      q = '0;
    else if (|shr[ACC_W:ACT_W])
      q = '1;
    else
      q = shr[ACT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_fsm && take_acc) begin
      lane_q[0] <= o_data1;
      lane_q[1] <= o_data2;
      lane_q[2] <= o_data3;
      lane_q[3] <= o_data4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_fsm && state == QUANT)
      mem[wr_ptr] <= q;
  end

  always_ff @(posedge clk) begin
    if (rst_fsm) begin
      state      <= IDLE;
      sh_q       <= '0;
      lane_idx   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      i_data     <= '0;
      data_valid <= 1'b0;
      layer_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      layer_done <= 1'b0;
      if (acc_valid && !acc_ready)
        ovf_err <= 1'b1;
      case (state)
        IDLE: begin
          if (take_acc) begin
            sh_q     <= sh_sel;
            lane_idx <= '0;
            state    <= QUANT;
          end else if (rd_start && count != 7'd0) begin
            data_valid <= 1'b1;
            i_data     <= mem[rd_ptr[PTR_W-1:0]];
            rd_ptr     <= rd_ptr + 7'd1;
            state      <= READ;
          end
        end
        QUANT: begin
          wr_ptr   <= wr_ptr + PTR_W'(1);
          count    <= count + 7'd1;
          lane_idx <= lane_idx + 2'd1;
          if (lane_idx == 2'd3)
            state <= IDLE;
        end
        READ: begin
          if (rd_ptr < count) begin
            data_valid <= 1'b1;
            i_data     <= mem[rd_ptr[PTR_W-1:0]];
            rd_ptr     <= rd_ptr + 7'd1;
          end else begin
            layer_done <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_requant_buffer.sv
// Directed bench for fc_requant_buffer: quantisation, fill/overflow,
// collisions, busy rejection and mid-operation reset.
module tb_fc_requant_buffer;

  logic        clk = 1'b0;
  logic        rst_fsm;
  logic [1:0]  layer_fc;
  logic        acc_valid;
  logic [43:0] o_data1;
  logic [43:0] o_data2;
  logic [43:0] o_data3;
  logic [43:0] o_data4;
  logic        acc_ready;
  logic        rd_start;
  logic [3:0]  i_data;
  logic        data_valid;
  logic        layer_done;
  logic [6:0]  count;
  logic        ovf_err;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fc_requant_buffer dut (
    .clk        (clk),
    .rst_fsm    (rst_fsm),
    .layer_fc   (layer_fc),
    .acc_valid  (acc_valid),
    .o_data1    (o_data1),
    .o_data2    (o_data2),
    .o_data3    (o_data3),
    .o_data4    (o_data4),
    .acc_ready  (acc_ready),
    .rd_start   (rd_start),
    .i_data     (i_data),
    .data_valid (data_valid),
    .layer_done (layer_done),
    .count      (count),
    .ovf_err    (ovf_err)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [1:0] l, input logic [43:0] a,
                           input logic [43:0] b, input logic [43:0] c,
                           input logic [43:0] d);
    layer_fc = l;
    o_data1  = a;
    o_data2  = b;
    o_data3  = c;
    o_data4  = d;
  endtask

  task automatic push(input logic [1:0] l, input logic [43:0] a,
                      input logic [43:0] b, input logic [43:0] c,
                      input logic [43:0] d);
    set_lanes(l, a, b, c, d);
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic replay(input int n);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("rd_valid", data_valid, 1);
      check("rd_data", i_data, exp_q[i]);
      tick();
    end
    check("rd_dv_off", data_valid, 0);
    check("rd_done", layer_done, 1);
    check("rd_count", count, 0);
    exp_q.delete();
  endtask

  task automatic do_reset;
    rst_fsm = 1'b1;
    tick();
    tick();
    rst_fsm = 1'b0;
  endtask

  initial begin
    rst_fsm   = 1'b0;
    acc_valid = 1'b0;
    rd_start  = 1'b0;
    set_lanes(2'd0, '0, '0, '0, '0);
    do_reset();
    check("rst_ready", acc_ready, 1);
    check("rst_count", count, 0);
    check("rst_dv", data_valid, 0);
    check("rst_done", layer_done, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_idata", i_data, 0);

    // basic S=8 with latency checks
    set_lanes(2'd0, 44'd896, 44'd127, 44'd128, 44'd3968);
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    check("q1_ready", acc_ready, 0);
    check("q1_count", count, 0);
    tick();
    check("q2_count", count, 1);
    tick();
    tick();
    check("q4_count", count, 3);
    tick();
    check("q5_count", count, 4);
    check("q5_ready", acc_ready, 1);
    exp_q = '{4, 0, 1, 15};
    replay(4);

    // relu + saturation at S=4
    push(2'd3, 44'hFFF_FFFF_FFFF, 44'h800_0000_0000,
         44'd240, 44'h7FF_FFFF_FFFF);
    exp_q = '{0, 0, 15, 15};
    replay(4);

    // fill to 64 then overflow
    for (int p = 0; p < 16; p++) begin
      push(2'd2, 44'(((4*p+0)%16)*64), 44'(((4*p+1)%16)*64),
           44'(((4*p+2)%16)*64), 44'(((4*p+3)%16)*64));
      if (p == 14) begin
        check("fill60_count", count, 60);
        check("fill60_ready", acc_ready, 1);
      end
    end
    check("full_count", count, 64);
    check("full_ready", acc_ready, 0);
    check("full_ovf", ovf_err, 0);
    push(2'd2, 44'd960, 44'd960, 44'd960, 44'd960);
    check("ovf_set", ovf_err, 1);
    check("ovf_count", count, 64);
    for (int i = 0; i < 64; i++) exp_q.push_back(i % 16);
    replay(64);
    check("ovf_sticky", ovf_err, 1);
    do_reset();
    check("ovf_clr", ovf_err, 0);

    // acc_valid and rd_start together
    push(2'd0, 44'd256, 44'd512, 44'd768, 44'd1024);
    set_lanes(2'd0, 44'd1280, 44'd1536, 44'd1792, 44'd2048);
    acc_valid = 1'b1;
    rd_start  = 1'b1;
    tick();
    acc_valid = 1'b0;
    rd_start  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("coll_dv", data_valid, 0);
      tick();
    end
    check("coll_count", count, 8);
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 8};
    replay(8);

    // rd_start on empty buffer
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("empty_dv", data_valid, 0);
      check("empty_done", layer_done, 0);
      tick();
    end
    check("empty_ready", acc_ready, 1);

    // busy rejection during QUANT
    set_lanes(2'd0, 44'd256, 44'd256, 44'd256, 44'd256);
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    tick();
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    check("busy_ovf", ovf_err, 1);
    tick();
    tick();
    check("busy_count", count, 4);
    repeat (6) tick();
    check("busy_count2", count, 4);

    // reset in 3rd READ cycle
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    tick();
    check("mrd_dv", data_valid, 1);
    rst_fsm = 1'b1;
    tick();
    rst_fsm = 1'b0;
    check("mrd_count", count, 0);
    check("mrd_dv0", data_valid, 0);
    check("mrd_ready", acc_ready, 1);
    check("mrd_ovf", ovf_err, 0);
    tick();
    check("mrd_done", layer_done, 0);

    // reset in 2nd QUANT cycle
    acc_valid = 1'b1;
    tick();
    tick();
    acc_valid = 1'b0;
    check("mq_ovf", ovf_err, 1);
    rst_fsm = 1'b1;
    tick();
    rst_fsm = 1'b0;
    check("mq_count", count, 0);
    check("mq_dv", data_valid, 0);
    check("mq_ready", acc_ready, 1);
    check("mq_ovf0", ovf_err, 0);
    repeat (4) tick();
    check("mq_count2", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fc_requant_buffer.md
Name: fc_requant_buffer

Overview:
- Downstream stage of fully_connected_all.
- Captures the four 44-bit signed accumulator lanes (o_data1..o_data4) when a layer step completes, then applies ReLU, a rounding right-shift and saturation to 4-bit unsigned activations.
- Stores the activations in a local buffer and replays them as the serial 4-bit i_data stream that feeds the next FC layer.

Parameters:
- ACC_W, 44, accumulator lane width
- ACT_W, 4, activation width (unsigned)
- DEPTH, 64, activation buffer entries (multiple of 4)
- SHIFT0, 8, right-shift amount when layer_fc=0 (every SHIFTn must be ≥1)
- SHIFT1, 8, right-shift amount when layer_fc=1
- SHIFT2, 6, right-shift amount when layer_fc=2
- SHIFT3, 4, right-shift amount when layer_fc=3

Ports:
- clk, input, 1, system clock; all logic on the rising edge
- rst_fsm, input, 1, synchronous active-high reset
- layer_fc, input, 2, layer select; chooses SHIFTn; sampled on acc_valid acceptance
- acc_valid, input, 1, one-cycle pulse: o_data1..4 hold final sums
- o_data1, input, ACC_W, lane 1 accumulator, signed two's complement
- o_data2, input, ACC_W, lane 2 accumulator, signed two's complement
- o_data3, input, ACC_W, lane 3 accumulator, signed two's complement
- o_data4, input, ACC_W, lane 4 accumulator, signed two's complement
- acc_ready, output, 1, block can accept acc_valid this cycle
- rd_start, input, 1, request replay of the buffered activations
- i_data, output, ACT_W, replayed activation
- data_valid, output, 1, i_data is valid this cycle
- layer_done, output, 1, one-cycle pulse after the last replayed activation
- count, output, 7, number of entries currently stored
- ovf_err, output, 1, sticky flag: acc_valid arrived while acc_ready was low

Behaviour:
- Reset values:
  - All outputs 0, except acc_ready=1.
  - State IDLE; wr_ptr, rd_ptr and count cleared.
  - Reset mid-QUANT or mid-READ aborts the operation immediately; buffer contents become don't-care.
- FSM states: IDLE, QUANT, READ.
- acc_ready = (state==IDLE) && (count ≤ DEPTH-4).
- IDLE:
  - acc_valid && acc_ready: latch all 4 lanes and the selected shift S, then go to QUANT.
  - Otherwise, rd_start && count>0: go to READ.
  - acc_valid and rd_start in the same cycle: acc_valid wins; rd_start is dropped.
  - rd_start with count==0: ignored.
- QUANT: exactly 4 cycles; cycle k processes lane k (lane 1 first).
  - v < 0 → result 0.
  - Otherwise r = (v + 2^(S-1)) >> S, computed at ACC_W+1 bits so the add cannot overflow.
  - r > 15 → 15.
  - The result is written to buf[wr_ptr]; wr_ptr++ and count++ on each write.
  - After the 4th write, return to IDLE.
- Capture-to-store latency: acc_valid accepted at cycle N → lane k written at the edge ending cycle N+k; acc_ready is high again at N+5 if space remains.
- Buffer full (count > DEPTH-4): acc_ready stays low until a READ completes.
- ovf_err is set on any acc_valid while acc_ready==0; that capture is discarded. ovf_err is cleared only by rst_fsm.
- READ:
  - rd_start accepted at cycle N → data_valid=1 and i_data=buf[rd_ptr] in cycles N+1 … N+count, in write order.
  - layer_done=1 in cycle N+count+1.
  - In that same cycle wr_ptr, rd_ptr and count are cleared and the FSM returns to IDLE.
  - acc_valid during READ: dropped and flagged in ovf_err.
  - rd_start during READ: ignored.
- data_valid is low in every other cycle; i_data holds its last value when data_valid is low.
- count is updated on the same edge as each write or clear.
- The buffer is plain registers or a synchronous-read array; no reset of contents is required.

Test Plan:
- Basic quantisation:
  - Stimulus: layer_fc=0 (S=8), o_data1..4 = 896, 127, 128, 3968; acc_valid pulse; then rd_start.
  - Response: count=4; replay i_data = 4, 0, 1, 15 on 4 consecutive data_valid cycles; layer_done one cycle later; count=0.
- ReLU and saturation:
  - Stimulus: layer_fc=3 (S=4), o_data = -1 (all ones), -2^43, 240, 2^43-1.
  - Response: replay 0, 0, 15, 15.
- Buffer fill and overflow:
  - Stimulus: 16 accepted acc_valid pulses (count=64), then a 17th pulse.
  - Response: acc_ready=0 from count=64; 17th capture discarded; ovf_err=1; a later rd_start replays all 64 entries in order.
- Simultaneous events:
  - Stimulus: acc_valid and rd_start in the same IDLE cycle with count=4.
  - Response: capture is taken; no data_valid; count=8 after QUANT.
  - Stimulus: rd_start with count=0.
  - Response: no response at all.
- Reset mid-operation:
  - Stimulus: rst_fsm asserted in the 2nd QUANT cycle, then in the 3rd READ cycle.
  - Response: next cycle count=0, data_valid=0, acc_ready=1, ovf_err=0, state IDLE.
- Busy rejection:
  - Stimulus: acc_valid pulse during QUANT.
  - Response: ignored; ovf_err=1; count advances by 4 only.
